// File: rtl/sreg_tx_arbiter_pkg.sv
// Shared definitions for the shift-register transmit arbiter: FSM state
// encoding and the default word width.
package sreg_ctrl_pkg;

    localparam int SREG_DEFAULT_N = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sreg_tx_arbiter_if.sv
// Bundle of the two requester handshakes and the shift-register control
// lines; slave is the arbiter side, master the producer/consumer side.
interface sreg_tx_arbiter_if
    import sreg_ctrl_pkg::*;
    #(parameter int N = SREG_DEFAULT_N) ();

    logic         a_valid;
    logic [N-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [N-1:0] b_data;
    logic         b_ready;
    logic         sr_load;
    logic         sr_shift;
    logic [N-1:0] sr_d;
    logic         sr_sin;
    logic         owner;
    logic         busy;
    logic         done;

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready, sr_load, sr_shift, sr_d, sr_sin, owner, busy, done
    );

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready, sr_load, sr_shift, sr_d, sr_sin, owner, busy, done
    );

endinterface

// File: rtl/sreg_tx_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant. On a tie the requester that did
// not own the previous frame wins; gnt_id is 1 when B is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    assign gnt_id = req[1] & (~req[0] | ~last_owner);
    assign gnt    = {req[1] & gnt_id, req[0] & ~gnt_id};

endmodule

// File: rtl/sreg_tx_arbiter.sv
// Time-shares one parallel-load shift register between requesters A and B:
// accept a word, pulse load, shift N times, pulse done, then arbitrate again.
module sreg_tx_arbiter
    import sreg_ctrl_pkg::*;
    #(parameter int N = SREG_DEFAULT_N) (
    input logic              clk,
    input logic              reset,
    sreg_tx_arbiter_if.slave bus
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  sr_d_q;
    logic          owner_q;
    logic          last_owner;
    logic [1:0]    gnt;
    logic          gnt_id;
    logic          grant_open;
    logic          accept;

    rr_arb2 u_arb (
        .req        ({bus.b_valid, bus.a_valid}),
        .last_owner (last_owner),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    // Ready is only offered in IDLE and never while reset is held, so no
    // word can be committed on the edge that aborts everything.
    assign grant_open  = (state == ST_IDLE) && !reset;
    assign bus.a_ready = grant_open & gnt[0];
    assign bus.b_ready = grant_open & gnt[1];
    assign accept      = grant_open & (gnt != 2'b00);

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            sr_d_q     <= '0;
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sr_d_q     <= gnt_id ? bus.b_data : bus.a_data;
                        owner_q    <= gnt_id;
                        last_owner <= gnt_id;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        state <= ST_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are pure state decodes: no input reaches them combinationally.
    assign bus.sr_load  = (state == ST_LOAD);
    assign bus.sr_shift = (state == ST_SHIFT);
    assign bus.done     = (state == ST_DONE);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.sr_d     = sr_d_q;
    assign bus.owner    = owner_q;
    assign bus.sr_sin   = 1'b0;

endmodule

// File: doc/sreg_tx_arbiter.md
# sreg_tx_arbiter

Two-requester controller that time-shares one N-bit parallel-load shift register (sregisterb-style: `load`, `d`, `sin`, `sout`). It accepts parallel words from requesters A and B over valid/ready handshakes and arbitrates between them round-robin. For each accepted word it issues one load strobe, then exactly N shift-enable cycles, then a one-cycle completion pulse. It sits between the producing logic and the shift register.

## Interface
Parameters:
- `N`, default 8: word width, which is also the shift count. N ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  requester A has a word.
- `a_data`  in  N  requester A word.
- `a_ready`  out  1  A word accepted this cycle when high together with `a_valid`.
- `b_valid`, `b_data`, `b_ready`: same as A, for requester B.
- `sr_load`  out  1  parallel-load strobe to the shift register.
- `sr_shift`  out  1  shift enable to the shift register.
- `sr_d`  out  N  word presented to the shift register's `d` input.
- `sr_sin`  out  1  serial fill bit; constant 0.
- `owner`  out  1  owner of the current frame: 0 = A, 1 = B.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last shift.

## Operation
- FSM states: IDLE → LOAD → SHIFT → DONE → IDLE.
- IDLE:
  - Grant rule:
    - Only A valid: grant A.
    - Only B valid: grant B.
    - Both valid: grant `~last_owner`.
  - The granted requester's `ready` is high combinationally in IDLE. The other `ready` stays 0.
  - On handshake:
    - Register the granted data into `sr_d`.
    - Set `owner` and `last_owner` to the granted requester.
    - Go to LOAD.
  - No valid: stay in IDLE.
- LOAD: `sr_load`=1 for exactly one cycle. Clear the bit counter. Go to SHIFT.
- SHIFT:
  - `sr_shift`=1 every cycle.
  - Counter increments from 0. After the cycle where the counter = N-1, go to DONE.
- DONE: `done`=1 for one cycle. Go to IDLE.
- `sr_load`, `sr_shift`, `done` and `busy` are decoded only from the state register, with no input-to-output path. The only combinational input paths are valid → ready.
- `sr_d` and `owner` hold their values from acceptance until the next acceptance.
- Counter width is `$clog2(N)`. It never wraps inside a frame.
- A requester may deassert `valid` at any cycle before a handshake. No commitment exists until valid && ready.

## Timing
- Handshake at edge T, then:
  - `sr_load` high during cycle T+1.
  - `sr_shift` high during cycles T+2 … T+N+1.
  - `done` high during cycle T+N+2.
  - Earliest next handshake at edge T+N+3.
- Frame period is N+3 cycles under continuous demand.
- Both `ready` outputs are 0 in every non-IDLE state. Valid asserted during a frame waits.
- Reset values:
  - State: IDLE.
  - `sr_load`, `sr_shift`, `done`, `busy`, `owner`: 0.
  - `sr_d`: 0.
  - Counter: 0.
  - `last_owner`: 1, so A wins the first tie.
- Reset asserted mid-frame:
  - The frame aborts at that edge.
  - No `done` pulse is issued.
  - Outputs take reset values on the next cycle.
  - No `ready` is high while `reset` is high.

## Structure
- Package `sreg_ctrl_pkg`:
  - FSM state type, 2-bit: IDLE=0, LOAD=1, SHIFT=2, DONE=3.
  - `SREG_DEFAULT_N = 8`.
- Sub-module `rr_arb2`:
  - Purely combinational two-way round-robin grant.
  - Inputs: `req[1:0]`, `last_owner`.
  - Outputs: `gnt[1:0]`, `gnt_id`.
- The top holds the FSM, bit counter, `sr_d`/`owner`/`last_owner` registers and the ready gating.

## Test plan
- Reset mid-frame: A sends 8'hC3, `reset` is asserted on the 3rd SHIFT cycle → next cycle all outputs 0 and state IDLE, no `done`. After release, A 8'h5A is accepted normally.
- Single requester: A sends 8'h99 → `a_ready` in the same cycle; `sr_d`=8'h99, `owner`=0; `sr_load` 1 cycle, `sr_shift` exactly 8 cycles, `done` 1 cycle; `busy` high for 10 cycles.
- Round-robin: A and B both held valid (A=8'h0F, B=8'hF0) from reset → grant order A, B, A, B. Handshakes are spaced exactly 11 cycles apart.
- Back-pressure: B asserts valid 8'h3C during A's SHIFT → `b_ready` stays 0 until IDLE, then B is accepted on the first IDLE cycle. `sr_d` changes only at that handshake.
- Withdrawn request: B pulses valid for one cycle while busy, then drops it → no B frame occurs and `last_owner` is unchanged.
- Parameter sweep: N=2 and N=16 → `sr_shift` high exactly N cycles per frame, period N+3.
